// File: rtl/gpo_pkg.sv
// Shared defaults and word type for the buffered GPO core and its FIFO.
package gpo_pkg;
    localparam int GPO_IN_WIDTH   = 128;
    localparam int GPO_OUT_WIDTH  = 64;
    localparam int GPO_FIFO_DEPTH = 4;

    typedef logic [GPO_IN_WIDTH-1:0] gpo_word_t;
endpackage

// File: rtl/gpo_core_buffered_if.sv
// Stimulus/result bundle between the AXI distribution side and the GPO core.
interface gpo_core_buffered_if
    import gpo_pkg::*;
#(
    parameter int IN_WIDTH   = GPO_IN_WIDTH,
    parameter int OUT_WIDTH  = GPO_OUT_WIDTH,
    parameter int FIFO_DEPTH = GPO_FIFO_DEPTH
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic                 override_en;
    logic [OUT_WIDTH-1:0] override_value;
    logic                 counter_matched;
    logic [IN_WIDTH-1:0]  gpo_in;
    logic                 busy;
    logic                 selected;
    logic                 overrided;
    logic                 overflow_error;
    logic [IN_WIDTH-1:0]  error_data;
    logic [CNT_W-1:0]     fifo_count;
    logic [OUT_WIDTH-1:0] gpo_out;

    modport slave (
        input  override_en, override_value, counter_matched, gpo_in, busy,
        output selected, overrided, overflow_error, error_data, fifo_count, gpo_out
    );

    modport master (
        output override_en, override_value, counter_matched, gpo_in, busy,
        input  selected, overrided, overflow_error, error_data, fifo_count, gpo_out
    );
endinterface

// File: rtl/gpo_sync_fifo.sv
// Small register-based FIFO with a combinational head; DEPTH must be a power of two.
module gpo_sync_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             CLK100MHZ,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_en, rd_en;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;
    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (wr_en && !rd_en) begin
            count_d = count_q + CNT_W'(1);
        end else if (rd_en && !wr_en) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge CLK100MHZ) begin
                if (wr_en && (wr_ptr_q == PTR_W'(gi))) begin
                    mem_q[gi] <= wr_data;
                end
            end
        end
    endgenerate
endmodule

// File: rtl/gpo_core_buffered.sv
// Buffered GPO core: queues matched words, drains one per idle cycle, with override and error capture.
module gpo_core_buffered
    import gpo_pkg::*;
#(
    parameter  int IN_WIDTH   = GPO_IN_WIDTH,
    parameter  int OUT_WIDTH  = GPO_OUT_WIDTH,
    parameter  int FIFO_DEPTH = GPO_FIFO_DEPTH,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                CLK100MHZ,
    input  logic                reset,
    gpo_core_buffered_if.slave  bus
);
    logic                 push, pop;
    logic                 fifo_full, fifo_empty;
    logic [OUT_WIDTH-1:0] fifo_head;
    logic [CNT_W-1:0]     fifo_count;
    logic                 overflow_d, overrided_d;

    logic                 selected_q, overrided_q, overflow_q;
    logic [IN_WIDTH-1:0]  error_data_q;
    logic [OUT_WIDTH-1:0] out_buf_q, ovr_reg_q;
    logic                 ovr_state_q;

    assign pop         = ~fifo_empty & ~bus.busy & ~bus.override_en;
    assign push        = bus.counter_matched & ~bus.override_en & (~fifo_full | pop);
    assign overrided_d = bus.counter_matched & bus.override_en;
    assign overflow_d  = bus.counter_matched & ~bus.override_en & fifo_full & ~pop;

    // Only the low OUT_WIDTH bits of a word can ever reach gpo_out, so only those are queued.
    gpo_sync_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK100MHZ (CLK100MHZ),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .wr_data   (bus.gpo_in[OUT_WIDTH-1:0]),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            selected_q   <= 1'b0;
            overrided_q  <= 1'b0;
            overflow_q   <= 1'b0;
            error_data_q <= '0;
            out_buf_q    <= '0;
            ovr_reg_q    <= '0;
            ovr_state_q  <= 1'b0;
        end else begin
            selected_q  <= pop;
            overrided_q <= overrided_d;
            overflow_q  <= overflow_d;
            if (overrided_d || overflow_d) error_data_q <= bus.gpo_in;
            if (pop) out_buf_q <= fifo_head;
            // The override word is only latched while downstream can accept it.
            ovr_state_q <= bus.override_en & ~bus.busy;
            if (bus.override_en && !bus.busy) ovr_reg_q <= bus.override_value;
        end
    end

    assign bus.selected       = selected_q;
    assign bus.overrided      = overrided_q;
    assign bus.overflow_error = overflow_q;
    assign bus.error_data     = error_data_q;
    assign bus.fifo_count     = fifo_count;
    assign bus.gpo_out        = ovr_state_q ? ovr_reg_q : out_buf_q;
endmodule

// File: tb/tb_gpo_core_buffered.sv
// Directed bench for gpo_core_buffered: default build plus two parameter variants.
module tb_gpo_core_buffered;
    import gpo_pkg::*;

    logic CLK100MHZ = 1'b0;
    logic reset     = 1'b1;
    int   errors    = 0;
    int   checks    = 0;

    always #5 CLK100MHZ = ~CLK100MHZ;

    gpo_core_buffered_if #(.IN_WIDTH(128), .OUT_WIDTH(64), .FIFO_DEPTH(4)) bus ();
    gpo_core_buffered_if #(.IN_WIDTH(64),  .OUT_WIDTH(32), .FIFO_DEPTH(2)) bus2 ();
    gpo_core_buffered_if #(.IN_WIDTH(64),  .OUT_WIDTH(32), .FIFO_DEPTH(8)) bus8 ();

    gpo_core_buffered #(.IN_WIDTH(128), .OUT_WIDTH(64), .FIFO_DEPTH(4)) u_dut (
        .CLK100MHZ (CLK100MHZ), .reset (reset), .bus (bus)
    );
    gpo_core_buffered #(.IN_WIDTH(64), .OUT_WIDTH(32), .FIFO_DEPTH(2)) u_dut2 (
        .CLK100MHZ (CLK100MHZ), .reset (reset), .bus (bus2)
    );
    gpo_core_buffered #(.IN_WIDTH(64), .OUT_WIDTH(32), .FIFO_DEPTH(8)) u_dut8 (
        .CLK100MHZ (CLK100MHZ), .reset (reset), .bus (bus8)
    );

    task automatic step();
        @(posedge CLK100MHZ);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.gpo_out !== 64'h0 || bus.selected !== 1'b0 || bus.fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs gpo_out=%h selected=%b count=%0d required 0/0/0",
                     bus.gpo_out, bus.selected, bus.fifo_count);
        end
        checks++;
        if (bus.overflow_error !== 1'b0 || bus.overrided !== 1'b0 || bus.error_data !== 128'h0) begin
            errors++;
            $display("FAIL reset_errors ovf=%b ovr=%b error_data=%h required 0/0/0",
                     bus.overflow_error, bus.overrided, bus.error_data);
        end
        $display("test_reset done");
    endtask

    task automatic test_latency();
        bus.counter_matched = 1'b1;
        bus.gpo_in          = 128'hA5;
        step();
        bus.counter_matched = 1'b0;
        checks++;
        if (bus.selected !== 1'b0 || bus.fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL lat_t1 selected=%b count=%0d required 0/1", bus.selected, bus.fifo_count);
        end
        step();
        checks++;
        if (bus.gpo_out !== 64'hA5 || bus.selected !== 1'b1 || bus.fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL lat_t2 gpo_out=%h selected=%b count=%0d required a5/1/0",
                     bus.gpo_out, bus.selected, bus.fifo_count);
        end
        step();
        checks++;
        if (bus.selected !== 1'b0) begin
            errors++;
            $display("FAIL lat_t3 selected=%b required 0", bus.selected);
        end
        $display("test_latency done");
    endtask

    task automatic test_overflow();
        bus.busy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.counter_matched = 1'b1;
            bus.gpo_in          = 128'(i);
            step();
        end
        checks++;
        if (bus.fifo_count !== 3'd4 || bus.overflow_error !== 1'b0) begin
            errors++;
            $display("FAIL ovf_fill count=%0d ovf=%b required 4/0", bus.fifo_count, bus.overflow_error);
        end
        bus.gpo_in = 128'd5;
        step();
        checks++;
        if (bus.overflow_error !== 1'b1 || bus.error_data !== 128'd5 || bus.fifo_count !== 3'd4) begin
            errors++;
            $display("FAIL ovf_pulse ovf=%b error_data=%h count=%0d required 1/5/4",
                     bus.overflow_error, bus.error_data, bus.fifo_count);
        end
        bus.counter_matched = 1'b0;
        bus.busy            = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (bus.gpo_out !== 64'(i) || bus.selected !== 1'b1 || bus.overflow_error !== 1'b0) begin
                errors++;
                $display("FAIL ovf_drain%0d gpo_out=%h selected=%b ovf=%b required %h/1/0",
                         i, bus.gpo_out, bus.selected, bus.overflow_error, 64'(i));
            end
        end
        step();
        checks++;
        if (bus.selected !== 1'b0 || bus.fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL ovf_end selected=%b count=%0d required 0/0", bus.selected, bus.fifo_count);
        end
        $display("test_overflow done");
    endtask

    task automatic test_full_pop_push();
        bus.busy = 1'b1;
        for (int i = 11; i <= 14; i++) begin
            bus.counter_matched = 1'b1;
            bus.gpo_in          = 128'(i);
            step();
        end
        bus.busy   = 1'b0;
        bus.gpo_in = 128'd15;
        step();
        bus.counter_matched = 1'b0;
        checks++;
        if (bus.gpo_out !== 64'd11 || bus.fifo_count !== 3'd4 || bus.overflow_error !== 1'b0) begin
            errors++;
            $display("FAIL full_swap gpo_out=%h count=%0d ovf=%b required b/4/0",
                     bus.gpo_out, bus.fifo_count, bus.overflow_error);
        end
        for (int i = 12; i <= 15; i++) begin
            step();
            checks++;
            if (bus.gpo_out !== 64'(i) || bus.selected !== 1'b1 || bus.fifo_count !== 3'(15 - i)) begin
                errors++;
                $display("FAIL full_drain%0d gpo_out=%h selected=%b count=%0d required %h/1/%0d",
                         i, bus.gpo_out, bus.selected, bus.fifo_count, 64'(i), 15 - i);
            end
        end
        step();
        $display("test_full_pop_push done");
    endtask

    task automatic test_override();
        bus.busy            = 1'b1;
        bus.counter_matched = 1'b1;
        bus.gpo_in          = 128'h21;
        step();
        bus.busy            = 1'b0;
        bus.override_en     = 1'b1;
        bus.override_value  = 64'hDEAD;
        bus.gpo_in          = 128'd7;
        step();
        bus.counter_matched = 1'b0;
        checks++;
        if (bus.gpo_out !== 64'hDEAD || bus.overrided !== 1'b1 || bus.error_data !== 128'd7) begin
            errors++;
            $display("FAIL ovr_enter gpo_out=%h overrided=%b error_data=%h required dead/1/7",
                     bus.gpo_out, bus.overrided, bus.error_data);
        end
        checks++;
        if (bus.fifo_count !== 3'd1 || bus.selected !== 1'b0 || bus.overflow_error !== 1'b0) begin
            errors++;
            $display("FAIL ovr_hold count=%0d selected=%b ovf=%b required 1/0/0",
                     bus.fifo_count, bus.selected, bus.overflow_error);
        end
        step();
        checks++;
        if (bus.gpo_out !== 64'hDEAD || bus.overrided !== 1'b0 || bus.fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL ovr_steady gpo_out=%h overrided=%b count=%0d required dead/0/1",
                     bus.gpo_out, bus.overrided, bus.fifo_count);
        end
        bus.override_en = 1'b0;
        step();
        checks++;
        if (bus.gpo_out !== 64'h21 || bus.selected !== 1'b1 || bus.fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL ovr_release gpo_out=%h selected=%b count=%0d required 21/1/0",
                     bus.gpo_out, bus.selected, bus.fifo_count);
        end
        step();
        $display("test_override done");
    endtask

    task automatic test_mid_reset();
        bus.busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.counter_matched = 1'b1;
            bus.gpo_in          = 128'(8'h31 + i);
            step();
        end
        bus.counter_matched = 1'b0;
        checks++;
        if (bus.fifo_count !== 3'd3) begin
            errors++;
            $display("FAIL rst_queued count=%0d required 3", bus.fifo_count);
        end
        reset = 1'b1;
        step();
        reset    = 1'b0;
        bus.busy = 1'b0;
        checks++;
        if (bus.fifo_count !== 3'd0 || bus.gpo_out !== 64'h0 || bus.error_data !== 128'h0) begin
            errors++;
            $display("FAIL rst_clear count=%0d gpo_out=%h error_data=%h required 0/0/0",
                     bus.fifo_count, bus.gpo_out, bus.error_data);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (bus.selected !== 1'b0 || bus.fifo_count !== 3'd0) begin
                errors++;
                $display("FAIL rst_after%0d selected=%b count=%0d required 0/0",
                         i, bus.selected, bus.fifo_count);
            end
        end
        $display("test_mid_reset done");
    endtask

    task automatic test_sweep_depth2();
        int n = 0;
        for (int r = 0; r < 3; r++) begin
            bus2.busy = 1'b1;
            for (int i = 0; i < 2; i++) begin
                bus2.counter_matched = 1'b1;
                bus2.gpo_in          = {32'hCAFE_0000, 32'(100 + n + i)};
                step();
            end
            bus2.counter_matched = 1'b0;
            bus2.busy            = 1'b0;
            checks++;
            if (bus2.fifo_count !== 2'd2) begin
                errors++;
                $display("FAIL d2_fill%0d count=%0d required 2", r, bus2.fifo_count);
            end
            for (int i = 0; i < 2; i++) begin
                step();
                checks++;
                if (bus2.gpo_out !== 32'(100 + n) || bus2.selected !== 1'b1) begin
                    errors++;
                    $display("FAIL d2_word%0d gpo_out=%h selected=%b required %h/1",
                             n, bus2.gpo_out, bus2.selected, 32'(100 + n));
                end
                n++;
            end
        end
        step();
        $display("test_sweep_depth2 done");
    endtask

    task automatic test_sweep_depth8();
        int n = 0;
        for (int r = 0; r < 3; r++) begin
            bus8.busy = 1'b1;
            for (int i = 0; i < 8; i++) begin
                bus8.counter_matched = 1'b1;
                bus8.gpo_in          = {32'hBEEF_0000, 32'(200 + n + i)};
                step();
            end
            bus8.counter_matched = 1'b0;
            bus8.busy            = 1'b0;
            checks++;
            if (bus8.fifo_count !== 4'd8) begin
                errors++;
                $display("FAIL d8_fill%0d count=%0d required 8", r, bus8.fifo_count);
            end
            for (int i = 0; i < 8; i++) begin
                step();
                checks++;
                if (bus8.gpo_out !== 32'(200 + n) || bus8.selected !== 1'b1) begin
                    errors++;
                    $display("FAIL d8_word%0d gpo_out=%h selected=%b required %h/1",
                             n, bus8.gpo_out, bus8.selected, 32'(200 + n));
                end
                n++;
            end
        end
        step();
        checks++;
        if (bus8.fifo_count !== 4'd0) begin
            errors++;
            $display("FAIL d8_end count=%0d required 0", bus8.fifo_count);
        end
        $display("test_sweep_depth8 done");
    endtask

    initial begin
        bus.override_en  = 1'b0; bus.override_value  = '0; bus.counter_matched  = 1'b0;
        bus.gpo_in       = '0;   bus.busy            = 1'b0;
        bus2.override_en = 1'b0; bus2.override_value = '0; bus2.counter_matched = 1'b0;
        bus2.gpo_in      = '0;   bus2.busy           = 1'b0;
        bus8.override_en = 1'b0; bus8.override_value = '0; bus8.counter_matched = 1'b0;
        bus8.gpo_in      = '0;   bus8.busy           = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        test_reset();
        test_latency();
        test_overflow();
        test_full_pop_push();
        test_override();
        test_mid_reset();
        test_sweep_depth2();
        test_sweep_depth8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
